seq_fixed_multiplier: RTL and testbench
=======================================

Name: seq_fixed_multiplier

Overview:
- Parametrised, iterative radix-2 shift-add unsigned multiplier with valid/ready handshakes on input and output.
- Offers four output-format modes: truncated mid slice, truncated high slice, rounded-and-saturated mid slice, and saturated low slice. Also raises an overflow flag.
- Successor to the combinational 16x16 dual-slice multiplier in the datapath. It trades latency for area and adds rounding, saturation and flow control.
- Sits between an operand FIFO/producer and the accumulator stage.

Parameters:
- WIDTH, 16: operand and result width. Must be even and at least 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept an operation.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- in_mode  in  2  format mode (mult_pkg::mode_e).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  formatted result.
- out_ovf  out  1  overflow/saturation flag for out_data.

Behaviour:
- The block has one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, counter and accumulator cleared.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b and in_mode, clear the 2*WIDTH-bit product, set count=0, go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - One iteration per cycle, LSB-first over b: if the current b bit is 1, product += a<<count. Then count++.
  - Exactly WIDTH iterations.
  - On the edge that completes iteration WIDTH, register the formatted result into out_data/out_ovf, set out_valid=1, go to DONE.
- FSM DONE:
  - out_valid=1. out_data and out_ovf are held stable while out_ready=0. in_valid is ignored.
  - On out_valid&&out_ready, set out_valid=0 and go to IDLE. in_ready is 1 from the next cycle.
  - No accept in the same cycle as the output handshake.
- Latency: out_valid is high WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- Formatting, where P is the full 2*WIDTH-bit product and H=WIDTH/2:
  - MODE_MID_TRUNC (0):
    - out = P[WIDTH+H-1:H]. The value wraps; it is not saturated.
    - ovf=1 if P[2W-1:W+H] is non-zero.
    - Bit-exact with the legacy select=0 output.
  - MODE_HIGH_TRUNC (1):
    - out = P[2W-1:W], ovf=0.
    - Bit-exact with the legacy select=1 output.
  - MODE_MID_RND_SAT (2):
    - r = P[2W-1:H] + P[H-1] (round half up).
    - If r >= 2^WIDTH, out=all-ones and ovf=1. Otherwise out=r[W-1:0] and ovf=0.
  - MODE_LOW_SAT (3):
    - If P[2W-1:W] is non-zero, out=all-ones and ovf=1. Otherwise out=P[W-1:0] and ovf=0.
- Boundaries:
  - A zero operand still takes the full WIDTH cycles; there is no early termination.
  - The all-ones times all-ones product must not lose its carry; the product register is 2*WIDTH bits plus an internal carry.
  - The mode is sampled only at accept. Changes to in_mode during BUSY/DONE have no effect.
  - rst_n asserted in any state immediately forces the reset values. A partial result is never emitted.
  - in_valid held high during BUSY/DONE is not consumed. The producer must hold its data until in_ready is high.

Decomposition:
- Package mult_pkg contains:
  - typedef enum logic [1:0] mode_e {MODE_MID_TRUNC, MODE_HIGH_TRUNC, MODE_MID_RND_SAT, MODE_LOW_SAT};
  - typedef enum logic [1:0] state_e {IDLE, BUSY, DONE}.
- Sub-module mult_format: purely combinational. Takes the 2*WIDTH product and mode, returns data and ovf, parametrised by WIDTH.
- mult_format is instantiated once and unit-tested separately.

Test Plan:
- All tests use WIDTH=16.
- Mode 0, a=0x0300, b=0x0200 (P=0x00060000): out_data=0x0600, ovf=0. out_valid rises exactly 16 cycles after the accept edge.
- Mode 1, a=0xFFFF, b=0xFFFF (P=0xFFFE0001): out_data=0xFFFE, ovf=0.
- Mode 2 with three operand pairs:
  - a=0x0180, b=0x0001 gives out=0x0002, ovf=0 (rounded up).
  - a=0x017F, b=0x0001 gives out=0x0001, ovf=0.
  - a=0x1000, b=0x1000 gives out=0xFFFF, ovf=1. The same operands in mode 0 give 0x0000 with ovf=1.
- Mode 3 with two operand pairs:
  - a=0x00FF, b=0x0101 gives out=0xFFFF, ovf=0.
  - a=0x0100, b=0x0100 gives out=0xFFFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and in_mode. out_data stays stable, in_ready=0, and a new operation is accepted only after the output handshake.
- Reset: drop rst_n during BUSY at iteration 7. out_valid=0 and in_ready=1 immediately. After release, 0x1234*0x0010 in mode 1 gives 0x0001.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the sequential fixed-point multiplier.
package mult_pkg;

   // Output-format selection, sampled once per operation at accept.
   typedef enum logic [1:0] {
      MODE_MID_TRUNC   = 2'd0,
      MODE_HIGH_TRUNC  = 2'd1,
      MODE_MID_RND_SAT = 2'd2,
      MODE_LOW_SAT     = 2'd3
   } mode_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_format.sv
// Combinational result formatter: selects, rounds and saturates a full product.
module mult_format
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [2*WIDTH-1:0] prod,
   input  mode_e              mode,
   output logic [WIDTH-1:0]   data,
   output logic               ovf
);

   localparam int unsigned H  = WIDTH / 2;
   // Rounded mid slice needs one extra bit so the +1 carry is visible.
   localparam int unsigned RW = WIDTH + H + 1;

   logic [RW-1:0] rnd;

   // Pick the slice for the requested mode and flag anything that did not fit.
   always_comb begin
      rnd  = {1'b0, prod[2*WIDTH-1:H]} + RW'(prod[H-1]);
      data = '0;
      ovf  = 1'b0;
      unique case (mode)
         MODE_MID_TRUNC: begin
            data = prod[WIDTH+H-1:H];
            ovf  = |prod[2*WIDTH-1:WIDTH+H];
         end
         MODE_HIGH_TRUNC: begin
            data = prod[2*WIDTH-1:WIDTH];
         end
         MODE_MID_RND_SAT: begin
            if (|rnd[RW-1:WIDTH]) begin
               data = '1;
               ovf  = 1'b1;
            end else begin
               data = rnd[WIDTH-1:0];
            end
         end
         MODE_LOW_SAT: begin
            if (|prod[2*WIDTH-1:WIDTH]) begin
               data = '1;
               ovf  = 1'b1;
            end else begin
               data = prod[WIDTH-1:0];
            end
         end
         default: begin
            data = '0;
            ovf  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_fixed_multiplier.sv
// Iterative radix-2 shift-add unsigned multiplier with valid/ready on both sides.
module seq_fixed_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic [2*WIDTH-1:0]  a_sh_q, a_sh_d;    // multiplicand, shifted left once per iteration
   logic [WIDTH-1:0]    b_sh_q, b_sh_d;    // multiplier, shifted right so bit 0 is current
   logic [2*WIDTH:0]    prod_q, prod_d;    // product plus carry guard bit
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic                out_ovf_q, out_ovf_d;

   logic [2*WIDTH:0]    prod_add;
   logic [WIDTH-1:0]    fmt_data;
   logic                fmt_ovf;

   // Partial product for this iteration; also feeds the formatter on the last one.
   assign prod_add = prod_q + (b_sh_q[0] ? {1'b0, a_sh_q} : '0);

   mult_format #(
      .WIDTH (WIDTH)
   ) u_format (
      .prod (prod_add[2*WIDTH-1:0]),
      .mode (mode_q),
      .data (fmt_data),
      .ovf  (fmt_ovf)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = {{WIDTH{1'b0}}, in_a};
               b_sh_d  = in_b;
               mode_d  = mode_e'(in_mode);
               prod_d  = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            prod_d = prod_add;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               out_data_d = fmt_data;
               out_ovf_d  = fmt_ovf;
               state_d    = DONE;
            end
         end
         DONE: begin
            // Accept is deliberately not allowed on the output-handshake edge.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= MODE_MID_TRUNC;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         prod_q     <= prod_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_seq_fixed_multiplier.sv
// Directed bench for seq_fixed_multiplier and its formatter.
module tb_seq_fixed_multiplier;
   import mult_pkg::*;

   localparam int unsigned W = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_ovf;

   logic [2*W-1:0] fmt_prod;
   mode_e          fmt_mode;
   logic [W-1:0]   fmt_data;
   logic           fmt_ovf;

   int errors = 0;
   int checks = 0;

   seq_fixed_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   mult_format #(
      .WIDTH (W)
   ) u_fmt (
      .prod (fmt_prod),
      .mode (fmt_mode),
      .data (fmt_data),
      .ovf  (fmt_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  mode;
      logic [15:0] exp_d;
      logic        exp_o;
   } op_vec_t;

   typedef struct {
      logic [31:0] p;
      logic [1:0]  mode;
      logic [15:0] exp_d;
      logic        exp_o;
   } fmt_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called #1 after an edge; waits (bounded) until the DUT can accept.
   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check({name, " in_ready timeout"}, 32'(in_ready), 32'd1);
   endtask

   // Counts edges until out_valid is seen, then checks latency, data and flag.
   task automatic collect(input string name, input logic [15:0] exp_d, input logic exp_o);
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, " latency"}, 32'(n), 32'd16);
      check({name, " data"}, 32'(out_data), 32'(exp_d));
      check({name, " ovf"}, 32'(out_ovf), 32'(exp_o));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input op_vec_t v);
      wait_ready(v.name);
      in_valid = 1'b1;
      in_a     = v.a;
      in_b     = v.b;
      in_mode  = v.mode;
      @(posedge clk);
      #1;
      // Scramble inputs during BUSY; the latched mode and operands must win.
      in_valid = 1'b0;
      in_mode  = ~v.mode;
      in_a     = ~v.a;
      in_b     = ~v.b;
      check({v.name, " in_ready busy"}, 32'(in_ready), 32'd0);
      collect(v.name, v.exp_d, v.exp_o);
   endtask

   op_vec_t  ops [9];
   fmt_vec_t fvs [6];

   initial begin
      int seen;
      ops[0] = '{"m0 300x200",  16'h0300, 16'h0200, 2'd0, 16'h0600, 1'b0};
      ops[1] = '{"m1 ffffxffff", 16'hFFFF, 16'hFFFF, 2'd1, 16'hFFFE, 1'b0};
      ops[2] = '{"m2 round up", 16'h0180, 16'h0001, 2'd2, 16'h0002, 1'b0};
      ops[3] = '{"m2 round dn", 16'h017F, 16'h0001, 2'd2, 16'h0001, 1'b0};
      ops[4] = '{"m2 sat",      16'h1000, 16'h1000, 2'd2, 16'hFFFF, 1'b1};
      ops[5] = '{"m0 wrap",     16'h1000, 16'h1000, 2'd0, 16'h0000, 1'b1};
      ops[6] = '{"m3 fits",     16'h00FF, 16'h0101, 2'd3, 16'hFFFF, 1'b0};
      ops[7] = '{"m3 sat",      16'h0100, 16'h0100, 2'd3, 16'hFFFF, 1'b1};
      ops[8] = '{"m3 zero a",   16'h0000, 16'hFFFF, 2'd3, 16'h0000, 1'b0};

      fvs[0] = '{32'h0000_FFFF, 2'd3, 16'hFFFF, 1'b0};
      fvs[1] = '{32'hFFFF_FF80, 2'd2, 16'hFFFF, 1'b1};
      fvs[2] = '{32'h00FF_FF7F, 2'd2, 16'hFFFF, 1'b0};
      fvs[3] = '{32'h00FF_FF80, 2'd2, 16'hFFFF, 1'b1};
      fvs[4] = '{32'h1234_5678, 2'd0, 16'h3456, 1'b1};
      fvs[5] = '{32'h1234_5678, 2'd1, 16'h1234, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = '0;
      out_ready = 1'b0;
      fmt_prod  = '0;
      fmt_mode  = MODE_MID_TRUNC;

      // Formatter unit checks.
      for (int i = 0; i < 6; i++) begin
         fmt_prod = fvs[i].p;
         fmt_mode = mode_e'(fvs[i].mode);
         #1;
         check($sformatf("fmt[%0d] data", i), 32'(fmt_data), 32'(fvs[i].exp_d));
         check($sformatf("fmt[%0d] ovf", i), 32'(fmt_ovf), 32'(fvs[i].exp_o));
      end

      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset out_ovf", 32'(out_ovf), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) run_op(ops[i]);

      // Backpressure: output held while in_valid/in_mode wiggle, no early accept.
      wait_ready("bp");
      in_valid = 1'b1;
      in_a     = 16'h0300;
      in_b     = 16'h0200;
      in_mode  = 2'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < 40) begin
         @(posedge clk);
         #1;
         seen++;
      end
      check("bp latency", 32'(seen), 32'd16);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_mode  = i[1:0];
         in_a     = 16'h0002;
         in_b     = 16'h0003;
         @(posedge clk);
         #1;
         check($sformatf("bp[%0d] out_data", i), 32'(out_data), 32'h0600);
         check($sformatf("bp[%0d] out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp[%0d] in_ready", i), 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b1;
      in_mode   = 2'd3;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp handshake out_valid", 32'(out_valid), 32'd0);
      check("bp no accept on handshake", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp accepted next", 32'(in_ready), 32'd0);
      collect("bp 2x3 m3", 16'h0006, 1'b0);

      // Reset in the middle of BUSY.
      wait_ready("rst");
      in_valid = 1'b1;
      in_a     = 16'h1234;
      in_b     = 16'h0010;
      in_mode  = 2'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 32'(out_valid), 32'd0);
      check("mid reset in_ready", 32'(in_ready), 32'd1);
      check("mid reset out_data", 32'(out_data), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("no partial result", 32'(seen), 32'd0);
      run_op('{"post reset m1", 16'h1234, 16'h0010, 2'd1, 16'h0001, 1'b0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
